// File: rtl/tdc_phase_detector.sv
// Counter-based time-to-digital phase detector between ref_clk_i and gen_clk_i.
// Produces a signed, saturating phase error in fpga_clk_i cycles, slip/timeout flags and a lock indicator.
module tdc_phase_detector #(
    parameter int unsigned ERR_W        = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOCK_THRESH  = 2,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_ni,
    input  logic                    enable_i,
    input  logic                    ref_clk_i,
    input  logic                    gen_clk_i,
    output logic signed [ERR_W-1:0] error_o,
    output logic                    error_valid_o,
    output logic                    slip_o,
    output logic                    locked_o
);

    localparam int unsigned CNT_W  = ERR_W - 1;
    localparam int unsigned SAT    = (2 ** (ERR_W - 1)) - 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        GEN_FIRST = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic [SYNC_STAGES-1:0] gen_sync_q, gen_sync_d;
    logic                   ref_hist_q, ref_hist_d;
    logic                   gen_hist_q, gen_hist_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0]       error_q, error_d;
    logic                   valid_q, valid_d;
    logic                   slip_q, slip_d;
    logic                   locked_q, locked_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [BAD_W-1:0]       bad_q, bad_d;

    logic             ref_e, gen_e;
    logic             res_vld, res_slip, res_neg, lock_in;
    logic [ERR_W-1:0] res_mag, cnt_inc;

    // Identical synchroniser + history chains on both inputs so their latency cancels
    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_clk_i};
        gen_sync_d = {gen_sync_q[SYNC_STAGES-2:0], gen_clk_i};
        ref_hist_d = ref_sync_q[SYNC_STAGES-1];
        gen_hist_d = gen_sync_q[SYNC_STAGES-1];
        ref_e      = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
        gen_e      = gen_sync_q[SYNC_STAGES-1] & ~gen_hist_q;
    end

    // Measurement FSM; a result is formed on the strobe cycle and registered next edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_vld  = 1'b0;
        res_slip = 1'b0;
        res_neg  = 1'b0;
        res_mag  = '0;
        cnt_inc  = (cnt_q == CNT_W'(SAT)) ? ERR_W'(SAT) : ERR_W'({1'b0, cnt_q} + ERR_W'(1));
        case (state_q)
            IDLE: begin
                if (ref_e && gen_e) begin
                    res_vld = 1'b1;
                end else if (ref_e) begin
                    state_d = REF_FIRST;
                    cnt_d   = '0;
                end else if (gen_e) begin
                    state_d = GEN_FIRST;
                    cnt_d   = '0;
                end
            end
            REF_FIRST, GEN_FIRST: begin
                res_neg = (state_q == GEN_FIRST);
                if ((state_q == REF_FIRST) ? gen_e : ref_e) begin
                    res_vld = 1'b1;
                    res_mag = cnt_inc;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((state_q == REF_FIRST) ? ref_e : gen_e) begin
                    res_vld  = 1'b1;
                    res_slip = 1'b1;
                    res_mag  = ERR_W'(SAT);
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(SAT)) begin
                    res_vld  = 1'b1;
                    res_slip = 1'b1;
                    res_mag  = ERR_W'(SAT);
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!enable_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            res_vld  = 1'b0;
            res_slip = 1'b0;
        end
    end

    // Result registers and hysteretic lock detector, updated alongside each valid pulse
    always_comb begin
        error_d  = error_q;
        valid_d  = res_vld;
        slip_d   = res_slip;
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        lock_in  = (res_mag <= ERR_W'(LOCK_THRESH)) && !res_slip;
        if (res_vld) begin
            error_d = res_neg ? ERR_W'(-res_mag) : res_mag;
            if (lock_in) begin
                bad_d  = '0;
                good_d = (good_q == GOOD_W'(LOCK_COUNT)) ? good_q : good_q + GOOD_W'(1);
            end else begin
                good_d = '0;
                bad_d  = (bad_q == BAD_W'(UNLOCK_COUNT)) ? bad_q : bad_q + BAD_W'(1);
            end
            if (res_slip || (bad_d >= BAD_W'(UNLOCK_COUNT))) begin
                locked_d = 1'b0;
            end else if (good_d >= GOOD_W'(LOCK_COUNT)) begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ref_sync_q <= '0;
            gen_sync_q <= '0;
            ref_hist_q <= 1'b0;
            gen_hist_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            error_q    <= '0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            locked_q   <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            ref_sync_q <= ref_sync_d;
            gen_sync_q <= gen_sync_d;
            ref_hist_q <= ref_hist_d;
            gen_hist_q <= gen_hist_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
            slip_q     <= slip_d;
            locked_q   <= locked_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign error_o       = $signed(error_q);
    assign error_valid_o = valid_q;
    assign slip_o        = slip_q;
    assign locked_o      = locked_q;

endmodule
